// File: rtl/mem_arb_pkg.sv
// Package: mem_arb_pkg
// Shared types for the data-memory arbiter.
//  - mem_dmem_pkt_t : request packet {rnw, addr[31:0], data[31:0]} (65 bits)
//  - dmem_mem_pkt_t : response packet {data[31:0]} (32 bits)
//  - arb_state_t    : arbiter FSM states
//  - arb_port_t     : requester port id (port 0 = mem stage, port 1 = debug/loader)
//  - ARB_NPORTS     : number of requester ports
package mem_arb_pkg;

    // Packet layouts shared with the mem stage and the dmem block.
    typedef struct packed {
        logic        rnw;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_dmem_pkt_t;

    typedef struct packed {
        logic [31:0] data;
    } dmem_mem_pkt_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef logic arb_port_t;

    localparam int ARB_NPORTS = 2;

endpackage

// File: rtl/dmem_arb_if.sv
// Interface: dmem_arb_if
// Bundles the two requester handshakes and the dmem-side handshake.
//  req0_vld/req0_pkt, rsp0_vld/rsp0_pkt : port 0 (mem stage)
//  req1_vld/req1_pkt, rsp1_vld/rsp1_pkt : port 1 (debug/loader)
//  arb_dmem_vld/arb_dmem_pkt            : request toward dmem
//  dmem_arb_vld/dmem_arb_pkt            : response from dmem
// Modports:
//  slave  : the arbiter's view
//  master : the surrounding system's view (requesters plus dmem)
interface dmem_arb_if;
    import mem_arb_pkg::*;

    logic          req0_vld;
    mem_dmem_pkt_t req0_pkt;
    logic          rsp0_vld;
    dmem_mem_pkt_t rsp0_pkt;

    logic          req1_vld;
    mem_dmem_pkt_t req1_pkt;
    logic          rsp1_vld;
    dmem_mem_pkt_t rsp1_pkt;

    logic          arb_dmem_vld;
    mem_dmem_pkt_t arb_dmem_pkt;
    logic          dmem_arb_vld;
    dmem_mem_pkt_t dmem_arb_pkt;

    modport slave (
        input  req0_vld, req0_pkt, req1_vld, req1_pkt, dmem_arb_vld, dmem_arb_pkt,
        output rsp0_vld, rsp0_pkt, rsp1_vld, rsp1_pkt, arb_dmem_vld, arb_dmem_pkt
    );

    modport master (
        output req0_vld, req0_pkt, req1_vld, req1_pkt, dmem_arb_vld, dmem_arb_pkt,
        input  rsp0_vld, rsp0_pkt, rsp1_vld, rsp1_pkt, arb_dmem_vld, arb_dmem_pkt
    );

endinterface

// File: rtl/mem_arb_rr.sv
// Module: mem_arb_rr
// Two-way round-robin picker, purely combinational.
//  req_i      in  2  request levels, bit n = port n
//  last_gnt_i in  1  port that received the previous grant
//  gnt_vld_o  out 1  some port is requesting
//  gnt_id_o   out 1  port to grant (valid when gnt_vld_o)
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [ARB_NPORTS-1:0] req_i,
    input  arb_port_t             last_gnt_i,
    output logic                  gnt_vld_o,
    output arb_port_t             gnt_id_o
);

    always_comb begin
        gnt_vld_o = |req_i;
        gnt_id_o  = 1'b0;
        if (req_i[0] && req_i[1]) begin
            // Both waiting: hand the grant to whoever did not get the last one.
            gnt_id_o = ~last_gnt_i;
        end else if (req_i[1]) begin
            gnt_id_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arb.sv
// Module: dmem_arb
// Arbitrates two requesters onto the single data-memory port, holds the
// granted request until dmem answers, routes the answer back to the owner
// and forces an error response if dmem stays silent for too long.
//  clk          in   clock
//  reset        in   synchronous active-high reset
//  bus          slave modport of dmem_arb_if (requester and dmem handshakes)
//  timeout_err  out  sticky flag, set by a timeout, cleared only by reset
// Parameters:
//  TIMEOUT_CYC  BUSY cycles before a forced error response (0 = never)
//  CNT_W        timeout counter width; must hold TIMEOUT_CYC
module dmem_arb
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arb_if.slave      bus,
    output logic           timeout_err
);

    localparam logic             TO_EN   = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    arb_state_t        state_q, state_d;
    mem_dmem_pkt_t     cmd_q, cmd_d;
    arb_port_t         owner_q, owner_d;
    arb_port_t         last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [ARB_NPORTS-1:0] req_vec;
    logic                  gnt_vld;
    arb_port_t             gnt_id;

    logic                  arb_vld;
    logic                  rsp_fire;
    dmem_mem_pkt_t         rsp_data;
    logic [ARB_NPORTS-1:0] rsp_vld;
    dmem_mem_pkt_t         rsp_pkt [ARB_NPORTS];

    assign req_vec = {bus.req1_vld, bus.req0_vld};

    mem_arb_rr u_rr (
        .req_i      (req_vec),
        .last_gnt_i (last_gnt_q),
        .gnt_vld_o  (gnt_vld),
        .gnt_id_o   (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        owner_d    = owner_q;
        last_gnt_d = last_gnt_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        arb_vld    = 1'b0;
        rsp_fire   = 1'b0;
        rsp_data   = '0;

        case (state_q)
            ARB_IDLE: begin
                // A dmem strobe seen here is a stale answer to a timed-out
                // access and is deliberately dropped.
                if (gnt_vld) begin
                    state_d    = ARB_BUSY;
                    cmd_d      = gnt_id ? bus.req1_pkt : bus.req0_pkt;
                    owner_d    = gnt_id;
                    last_gnt_d = gnt_id;
                    cnt_d      = '0;
                end
            end
            ARB_BUSY: begin
                arb_vld = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.dmem_arb_vld) begin
                    // A real answer beats a timeout landing in the same cycle.
                    rsp_fire = 1'b1;
                    rsp_data = bus.dmem_arb_pkt;
                    state_d  = ARB_IDLE;
                    cnt_d    = '0;
                end else if (TO_EN && (cnt_q == TO_LAST)) begin
                    rsp_fire = 1'b1;
                    rsp_data = '0;
                    err_d    = 1'b1;
                    state_d  = ARB_IDLE;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            cmd_q      <= '0;
            owner_q    <= 1'b0;
            last_gnt_q <= 1'b1;     // so port 0 wins the first contention
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            owner_q    <= owner_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // Response steering: only the owner sees the pulse; the other port's
    // data is forced to zero so nothing leaks across requesters.
    genvar gi;
    generate
        for (gi = 0; gi < ARB_NPORTS; gi++) begin : g_rsp
            assign rsp_vld[gi] = rsp_fire && (owner_q == arb_port_t'(gi));
            assign rsp_pkt[gi] = rsp_vld[gi] ? rsp_data : '0;
        end
    endgenerate

    assign bus.rsp0_vld     = rsp_vld[0];
    assign bus.rsp0_pkt     = rsp_pkt[0];
    assign bus.rsp1_vld     = rsp_vld[1];
    assign bus.rsp1_pkt     = rsp_pkt[1];
    assign bus.arb_dmem_vld = arb_vld;
    assign bus.arb_dmem_pkt = cmd_q;
    assign timeout_err      = err_q;

endmodule

// File: tb/tb_dmem_arb.sv
`timescale 1ns/1ps
module tb_dmem_arb;
    import mem_arb_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic err_m, err_t;

    always #5 clk = ~clk;

    dmem_arb_if m();
    dmem_arb_if t();

    dmem_arb #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
        .clk(clk), .reset(reset), .bus(m.slave), .timeout_err(err_m)
    );

    dmem_arb #(.TIMEOUT_CYC(4), .CNT_W(3)) dut_to (
        .clk(clk), .reset(reset), .bus(t.slave), .timeout_err(err_t)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic mem_dmem_pkt_t pk(input logic rnw, input logic [31:0] a, input logic [31:0] d);
        mem_dmem_pkt_t p;
        p.rnw  = rnw;
        p.addr = a;
        p.data = d;
        return p;
    endfunction

    // ---------------- scoreboard on the main DUT ----------------
    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_rsp_t;

    exp_rsp_t sb_q[$];
    exp_rsp_t sb_e;

    always @(negedge clk) begin
        if (!reset && (m.rsp0_vld || m.rsp1_vld)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_rsp", 65'({m.rsp1_vld, m.rsp0_vld}), 65'(0));
            end else begin
                sb_e = sb_q.pop_front();
                chk("rsp_port", 65'({m.rsp1_vld, m.rsp0_vld}), sb_e.port ? 65'(2'b10) : 65'(2'b01));
                chk("rsp_data", 65'(sb_e.port ? m.rsp1_pkt : m.rsp0_pkt), 65'(sb_e.data));
                chk("nonowner_pkt", 65'(sb_e.port ? m.rsp0_pkt : m.rsp1_pkt), 65'(0));
                $display("rsp port=%0d data=%08h", sb_e.port, sb_e.data);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic          v0;
        mem_dmem_pkt_t p0;
        logic          v1;
        mem_dmem_pkt_t p1;
        logic          chg1;      // rewrite req1_pkt during the BUSY phase
        mem_dmem_pkt_t p1_new;
        int            lat;       // BUSY cycles before dmem answers
        logic [31:0]   rdata;
        logic          gnt;       // expected granted port
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v0, input mem_dmem_pkt_t p0, input logic v1, input mem_dmem_pkt_t p1,
                       input logic chg1, input mem_dmem_pkt_t p1_new, input int lat,
                       input logic [31:0] rdata, input logic gnt);
        vec_t v;
        v.v0 = v0; v.p0 = p0; v.v1 = v1; v.p1 = p1;
        v.chg1 = chg1; v.p1_new = p1_new; v.lat = lat; v.rdata = rdata; v.gnt = gnt;
        vecs.push_back(v);
    endtask

    // Called just after a rising edge with the DUT idle in the current cycle.
    // Returns just after the edge that ends the response cycle.
    task automatic serve(input vec_t v);
        int busy;
        exp_rsp_t er;
        m.req0_vld = v.v0; m.req0_pkt = v.p0;
        m.req1_vld = v.v1; m.req1_pkt = v.p1;
        @(negedge clk);
        chk("idle_before_gnt", 65'(m.arb_dmem_vld), 65'(0));
        @(posedge clk); #1;
        if (v.chg1) m.req1_pkt = v.p1_new;
        busy = 0;
        for (int i = 0; i < v.lat; i++) begin
            @(negedge clk);
            if (m.arb_dmem_vld) busy++;
            @(posedge clk); #1;
        end
        m.dmem_arb_vld = 1'b1;
        m.dmem_arb_pkt = v.rdata;
        er.port = v.gnt;
        er.data = v.rdata;
        sb_q.push_back(er);
        @(negedge clk);
        chk("arb_vld_cycles", 65'(busy + int'(m.arb_dmem_vld)), 65'(v.lat + 1));
        chk("arb_pkt", 65'(m.arb_dmem_pkt), 65'(v.gnt ? v.p1 : v.p0));
        $display("grant port=%0d pkt=%017h lat=%0d", v.gnt, m.arb_dmem_pkt, v.lat);
        @(posedge clk); #1;
        m.dmem_arb_vld = 1'b0;
        m.dmem_arb_pkt = '0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_arb_vld"}, 65'(m.arb_dmem_vld), 65'(0));
        chk({tag, "_arb_pkt"}, 65'(m.arb_dmem_pkt), 65'(0));
        chk({tag, "_rsp_vld"}, 65'({m.rsp1_vld, m.rsp0_vld}), 65'(0));
        chk({tag, "_rsp_pkt"}, 65'({m.rsp1_pkt, m.rsp0_pkt}), 65'(0));
        chk({tag, "_err"}, 65'(err_m), 65'(0));
    endtask

    initial begin
        mem_dmem_pkt_t z;
        vec_t v;
        z = '0;
        m.req0_vld = 0; m.req0_pkt = '0; m.req1_vld = 0; m.req1_pkt = '0;
        m.dmem_arb_vld = 0; m.dmem_arb_pkt = '0;
        t.req0_vld = 0; t.req0_pkt = '0; t.req1_vld = 0; t.req1_pkt = '0;
        t.dmem_arb_vld = 0; t.dmem_arb_pkt = '0;

        //   v0 p0                          v1 p1                          chg1 p1_new                        lat rdata          gnt
        add(1, pk(0, 32'h100, 32'h11111111), 1, pk(1, 32'h200, 0),          0, z,                              0, 32'h0000A0A0, 0);
        add(1, pk(1, 32'h104, 0),          1, pk(1, 32'h200, 0),          0, z,                              1, 32'hB1B1B1B1, 1);
        add(1, pk(1, 32'h104, 0),          1, pk(0, 32'h204, 32'h22222222), 0, z,                            2, 32'hC2C2C2C2, 0);
        add(0, z,                          1, pk(0, 32'h204, 32'h22222222), 0, z,                            0, 32'hD3D3D3D3, 1);
        add(1, pk(1, 32'h10, 0),           0, z,                          0, z,                              3, 32'hDEADBEEF, 0);
        add(1, pk(1, 32'h14, 0),           0, z,                          0, z,                              1, 32'hE5E5E5E5, 0);
        add(0, z,                          1, pk(1, 32'h300, 0),          0, z,                              2, 32'hF6F6F6F6, 1);
        add(1, pk(0, 32'h400, 32'h5A5A5A5A), 1, pk(1, 32'h600, 0),        1, pk(0, 32'h604, 32'h0F0F0F0F),   2, 32'h55AA55AA, 0);
        add(0, z,                          1, pk(0, 32'h604, 32'h0F0F0F0F), 1, pk(1, 32'h608, 0),            1, 32'h66CC66CC, 1);

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("reset");
        chk("reset_err_to", 65'(err_t), 65'(0));
        @(posedge clk); #1;

        foreach (vecs[i]) serve(vecs[i]);
        m.req0_vld = 0; m.req1_vld = 0;

        // Reset while BUSY, then a fresh port 1 request.
        m.req0_vld = 1; m.req0_pkt = pk(1, 32'h40, 0);
        @(negedge clk);
        chk("pre_rst_idle", 65'(m.arb_dmem_vld), 65'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("pre_rst_busy", 65'(m.arb_dmem_vld), 65'(1));
        @(posedge clk); #1;
        reset = 1'b1; m.req0_vld = 0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk_reset_vals("busy_reset");
        @(posedge clk); #1;
        v.v0 = 0; v.p0 = z; v.v1 = 1; v.p1 = pk(0, 32'h500, 32'hABCD0123);
        v.chg1 = 0; v.p1_new = z; v.lat = 1; v.rdata = 32'h00000077; v.gnt = 1;
        serve(v);
        m.req1_vld = 0;
        chk("sb_empty", 65'(sb_q.size()), 65'(0));
        chk("main_err_clear", 65'(err_m), 65'(0));

        // Race on the 4-cycle-timeout instance: answer in the last allowed cycle.
        t.req0_vld = 1; t.req0_pkt = pk(1, 32'h80, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("race_no_early_rsp", 65'(t.rsp0_vld), 65'(0));
            @(posedge clk); #1;
        end
        t.dmem_arb_vld = 1; t.dmem_arb_pkt = 32'hCAFEF00D;
        @(negedge clk);
        chk("race_rsp_vld", 65'({t.rsp1_vld, t.rsp0_vld}), 65'(2'b01));
        chk("race_rsp_data", 65'(t.rsp0_pkt), 65'(32'hCAFEF00D));
        $display("race rsp data=%08h", t.rsp0_pkt);
        @(posedge clk); #1;
        t.dmem_arb_vld = 0; t.dmem_arb_pkt = '0; t.req0_vld = 0;
        @(negedge clk);
        chk("race_no_err", 65'(err_t), 65'(0));
        chk("race_idle", 65'(t.arb_dmem_vld), 65'(0));

        // Timeout: dmem stays silent.
        @(posedge clk); #1;
        t.req0_vld = 1; t.req0_pkt = pk(0, 32'h84, 32'h99);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_wait_rsp", 65'(t.rsp0_vld), 65'(0));
            chk("to_wait_busy", 65'(t.arb_dmem_vld), 65'(1));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("to_rsp_vld", 65'({t.rsp1_vld, t.rsp0_vld}), 65'(2'b01));
        chk("to_rsp_data", 65'(t.rsp0_pkt), 65'(0));
        chk("to_err_not_yet", 65'(err_t), 65'(0));
        $display("timeout rsp data=%08h", t.rsp0_pkt);
        @(posedge clk); #1;
        t.req0_vld = 0;
        t.dmem_arb_vld = 1; t.dmem_arb_pkt = 32'h12345678;
        @(negedge clk);
        chk("to_err_set", 65'(err_t), 65'(1));
        chk("late_rsp_ignored", 65'({t.rsp1_vld, t.rsp0_vld}), 65'(0));
        chk("late_idle", 65'(t.arb_dmem_vld), 65'(0));
        @(posedge clk); #1;
        t.dmem_arb_vld = 0; t.dmem_arb_pkt = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("to_err_sticky", 65'(err_t), 65'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
